// File: rtl/op_seq_controller.sv
// Operand/opcode sequencer: issues num_pairs LFSR-generated A/B pairs with an opcode
// over a valid/ready handshake, then pulses done. Abort returns to IDLE immediately.
module op_seq_controller #(
    parameter int                WIDTH = 7,
    parameter int                OPW   = 1,
    parameter int                CNTW  = 8,
    parameter logic [WIDTH-1:0]  TAPS  = 7'h60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [OPW-1:0]   op_sel,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNTW-1:0]  num_pairs,
    input  logic             ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [OPW-1:0]   OP,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  pair_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CNTW-1:0] np_q;
    logic            mode_q;
    logic [CNTW-1:0] cnt_inc;
    logic            handshake;
    logic            last_pair;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : '0);
    endfunction

    assign cnt_inc   = pair_count + 1'b1;
    assign handshake = (state == ISSUE) && ready;
    assign last_pair = (cnt_inc == np_q);

    assign valid = (state == ISSUE);
    assign busy  = (state == ISSUE);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort outranks a handshake on the final pair, so no done pulse follows an abort.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_pairs != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (ready && last_pair) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            A          <= '0;
            B          <= '0;
            OP         <= '0;
            pair_count <= '0;
            np_q       <= '0;
            mode_q     <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                np_q       <= num_pairs;
                mode_q     <= mode;
                pair_count <= '0;
                // An all-zero LFSR state would lock up, so zero seeds are replaced by 1.
                if (num_pairs != '0) begin
                    A  <= (seed == '0) ? WIDTH'(1) : seed;
                    B  <= ((~seed) == '0) ? WIDTH'(1) : ~seed;
                    OP <= mode ? op_sel : '0;
                end
            end
            if (handshake) begin
                if (pair_count != '1) begin
                    pair_count <= cnt_inc;
                end
                if (!abort && !last_pair) begin
                    A <= lfsr_step(A);
                    B <= lfsr_step(B);
                    if (!mode_q) begin
                        OP <= OP + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_op_seq_controller.sv
// Self-checking bench for op_seq_controller: table vectors, directed corner sequences
// and random stimulus compared against a sequence-level reference model.
module tb_op_seq_controller;

    localparam logic [6:0] TAPS    = 7'h60;
    localparam int         NUM_OPS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mode = 1'b0;
    logic [0:0] op_sel = '0;
    logic [6:0] seed = '0;
    logic [7:0] num_pairs = '0;
    logic       ready = 1'b0;
    logic [6:0] A;
    logic [6:0] B;
    logic [0:0] OP;
    logic       valid;
    logic       busy;
    logic       done;
    logic [7:0] pair_count;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: which pair of the sequence is on display, not how it is stored.
    bit         m_active;
    bit         m_done;
    int         m_cnt;
    int         m_np;
    int         m_show;
    int         m_abmode;
    logic [6:0] m_a0;
    logic [6:0] m_b0;
    bit         m_mode;
    int         m_opsel;

    typedef struct {
        logic       r, s, ab, md;
        logic [0:0] ops;
        logic [6:0] sd;
        logic [7:0] np;
        logic       rdy;
        logic       exp_valid, exp_busy, exp_done;
        logic [6:0] exp_a, exp_b;
        logic [0:0] exp_op;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];

    op_seq_controller dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .op_sel(op_sel), .seed(seed), .num_pairs(num_pairs), .ready(ready),
        .A(A), .B(B), .OP(OP), .valid(valid), .busy(busy), .done(done),
        .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] lfsrN(input logic [6:0] x, input int n);
        logic [6:0] v;
        v = x;
        for (int i = 0; i < n; i++) begin
            v = (v >> 1) ^ (v[0] ? TAPS : 7'h00);
        end
        return v;
    endfunction

    task automatic modelStep();
        bit hs;
        if (reset) begin
            m_active = 0; m_done = 0; m_cnt = 0; m_abmode = 0; m_show = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            hs = ready;
            if (hs) m_cnt++;
            if (abort) begin
                m_active = 0;
                m_abmode = 2;
            end else if (hs && m_cnt == m_np) begin
                m_active = 0;
                m_done = 1;
                m_show = m_np - 1;
            end else if (hs) begin
                m_show = m_cnt;
            end
        end else if (start) begin
            m_cnt = 0;
            m_np = int'(num_pairs);
            m_mode = mode;
            m_opsel = int'(op_sel);
            if (m_np == 0) begin
                m_done = 1;
                m_abmode = 2;
            end else begin
                m_active = 1;
                m_abmode = 1;
                m_show = 0;
                m_a0 = (seed == 7'h00) ? 7'h01 : seed;
                m_b0 = (~seed == 7'h00) ? 7'h01 : ~seed;
            end
        end
    endtask

    task automatic checkField(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        int expA, expB, expOp;
        checkField({tag, "_valid"}, int'(valid), int'(m_active));
        checkField({tag, "_busy"}, int'(busy), int'(m_active));
        checkField({tag, "_done"}, int'(done), int'(m_done));
        checkField({tag, "_count"}, int'(pair_count), m_cnt);
        if (m_abmode != 2) begin
            expA  = (m_abmode == 0) ? 0 : int'(lfsrN(m_a0, m_show));
            expB  = (m_abmode == 0) ? 0 : int'(lfsrN(m_b0, m_show));
            expOp = (m_abmode == 0) ? 0 : (m_mode ? m_opsel : m_show % NUM_OPS);
            checkField({tag, "_A"}, int'(A), expA);
            checkField({tag, "_B"}, int'(B), expB);
            checkField({tag, "_OP"}, int'(OP), expOp);
        end
    endtask

    task automatic applyStimulus(input logic r, s, ab, md, input logic [0:0] ops,
                                 input logic [6:0] sd, input logic [7:0] np,
                                 input logic rdy, input string tag);
        reset = r; start = s; abort = ab; mode = md;
        op_sel = ops; seed = sd; num_pairs = np; ready = rdy;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int doneSeen;
        int opOnes;
        vec_t v;

        // Basic sweep sequence, then ready held low for four cycles and an abort.
        tbl.push_back('{1,0,0,0,0,7'h00,8'd0,0, 0,0,0,7'h00,7'h00,0,8'd0});
        tbl.push_back('{0,1,0,0,0,7'h01,8'd3,1, 1,1,0,7'h01,7'h7E,0,8'd0});
        tbl.push_back('{0,0,0,0,0,7'h01,8'd3,1, 1,1,0,7'h60,7'h3F,1,8'd1});
        tbl.push_back('{0,0,0,0,0,7'h01,8'd3,1, 1,1,0,7'h30,7'h7F,0,8'd2});
        tbl.push_back('{0,0,0,0,0,7'h01,8'd3,1, 0,0,1,7'h30,7'h7F,0,8'd3});
        tbl.push_back('{0,0,0,0,0,7'h01,8'd3,0, 0,0,0,7'h30,7'h7F,0,8'd3});
        tbl.push_back('{0,1,0,0,0,7'h01,8'd3,0, 1,1,0,7'h01,7'h7E,0,8'd0});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{0,0,0,0,0,7'h01,8'd3,0, 1,1,0,7'h01,7'h7E,0,8'd0});
        tbl.push_back('{0,0,1,0,0,7'h01,8'd3,0, 0,0,0,7'h01,7'h7E,0,8'd0});

        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            applyStimulus(v.r, v.s, v.ab, v.md, v.ops, v.sd, v.np, v.rdy, $sformatf("row%0d", i));
            checkField($sformatf("tbl%0d_valid", i), int'(valid), int'(v.exp_valid));
            checkField($sformatf("tbl%0d_busy", i), int'(busy), int'(v.exp_busy));
            checkField($sformatf("tbl%0d_done", i), int'(done), int'(v.exp_done));
            checkField($sformatf("tbl%0d_A", i), int'(A), int'(v.exp_a));
            checkField($sformatf("tbl%0d_B", i), int'(B), int'(v.exp_b));
            checkField($sformatf("tbl%0d_OP", i), int'(OP), int'(v.exp_op));
            checkField($sformatf("tbl%0d_count", i), int'(pair_count), int'(v.exp_cnt));
        end

        // Fixed opcode mode: every handshake carries op_sel, exactly one done pulse.
        applyStimulus(0, 1, 0, 1, 1'b1, 7'h55, 8'd4, 1, "fix_start");
        doneSeen = 0;
        opOnes = (valid && OP == 1'b1) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 1, 1'b0, 7'h00, 8'd0, 1, "fix_run");
            if (valid && OP == 1'b1) opOnes++;
            if (done) doneSeen++;
        end
        checkField("fix_op_count", opOnes, 4);
        checkField("fix_done_pulses", doneSeen, 1);

        // Zero pairs: straight to a single done pulse.
        applyStimulus(0, 1, 0, 0, 1'b0, 7'h12, 8'd0, 1, "zero_start");
        checkField("zero_done", int'(done), 1);
        checkField("zero_valid", int'(valid), 0);
        applyStimulus(0, 0, 0, 0, 1'b0, 7'h12, 8'd0, 1, "zero_after");
        checkField("zero_done_clear", int'(done), 0);

        // Abort after two of five handshakes.
        applyStimulus(0, 1, 0, 0, 1'b0, 7'h2A, 8'd5, 1, "abort_start");
        applyStimulus(0, 0, 0, 0, 1'b0, 7'h2A, 8'd5, 1, "abort_hs1");
        applyStimulus(0, 0, 0, 0, 1'b0, 7'h2A, 8'd5, 1, "abort_hs2");
        applyStimulus(0, 0, 1, 0, 1'b0, 7'h2A, 8'd5, 0, "abort_hit");
        checkField("abort_count", int'(pair_count), 2);
        checkField("abort_busy", int'(busy), 0);
        applyStimulus(0, 0, 0, 0, 1'b0, 7'h2A, 8'd5, 0, "abort_idle");
        checkField("abort_no_done", int'(done), 0);

        // Abort coinciding with the final handshake: counted, but no done pulse.
        applyStimulus(0, 1, 0, 0, 1'b0, 7'h33, 8'd2, 1, "prio_start");
        applyStimulus(0, 0, 0, 0, 1'b0, 7'h33, 8'd2, 1, "prio_hs1");
        applyStimulus(0, 0, 1, 0, 1'b0, 7'h33, 8'd2, 1, "prio_hit");
        checkField("prio_count", int'(pair_count), 2);
        checkField("prio_done", int'(done), 0);
        applyStimulus(0, 0, 0, 0, 1'b0, 7'h33, 8'd2, 1, "prio_after");
        checkField("prio_done_late", int'(done), 0);

        // Reset mid-sequence overrides everything, then a zero seed start.
        applyStimulus(0, 1, 0, 0, 1'b0, 7'h44, 8'd5, 1, "rst_start");
        applyStimulus(0, 0, 0, 0, 1'b0, 7'h44, 8'd5, 1, "rst_hs");
        applyStimulus(1, 1, 1, 0, 1'b0, 7'h44, 8'd5, 1, "rst_hit");
        applyStimulus(0, 0, 0, 0, 1'b0, 7'h44, 8'd5, 1, "rst_idle");
        checkField("rst_A", int'(A), 0);
        checkField("rst_count", int'(pair_count), 0);
        applyStimulus(0, 1, 0, 0, 1'b0, 7'h00, 8'd2, 0, "seed0_start");
        checkField("seed0_A", int'(A), 'h01);
        checkField("seed0_B", int'(B), 'h7F);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] sd;
            logic [7:0] np;
            sd = 7'($urandom);
            if ($urandom_range(0, 15) == 0) sd = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h7F;
            np = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 19) == 0, 1'($urandom), 1'($urandom),
                          sd, np, $urandom_range(0, 2) != 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
